// File: rtl/s16_cpu_if.sv
// rtl/s16_cpu_if.sv - debug/observation bundle for the s16_cpu core
// The core is the slave; whoever selects registers and watches pc/halt is the master.
interface s16_cpu_if;
  logic [2:0]  dbg_reg_sel;
  logic [15:0] dbg_reg_data;
  logic [15:0] pc;
  logic        halted;

  modport master (output dbg_reg_sel, input dbg_reg_data, input pc, input halted);
  modport slave  (input dbg_reg_sel, output dbg_reg_data, output pc, output halted);
endinterface

// File: rtl/s16_cpu.sv
// rtl/s16_cpu.sv - 16-bit single-cycle CPU core
// Fetch, decode, register read, ALU and data-memory read settle combinationally; all state commits on one edge.
module s16_cpu #(
  parameter int    IMEM_DEPTH = 256,
  parameter int    DMEM_DEPTH = 256,
  parameter string IMEM_FILE  = "program.mem"
) (
  input logic      clk,
  input logic      reset,
  s16_cpu_if.slave dbg
);
  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] rf_q [8];
  logic [15:0] imem [IMEM_DEPTH];
  logic [15:0] dmem [DMEM_DEPTH];

  logic [15:0] instr;
  logic [3:0]  op;
  logic [2:0]  rd, rs, rt, fn;
  logic [15:0] rd_val, rs_val, rt_val;
  logic [15:0] simm6, simm9, sum_imm, br_target, ld_data;
  logic [15:0] alu_y;
  logic        rf_we, dm_we;
  logic [15:0] rf_wdata;

  assign instr     = imem[pc_q[7:0]];
  assign op        = instr[15:12];
  assign rd        = instr[11:9];
  assign rs        = instr[8:6];
  assign rt        = instr[5:3];
  assign fn        = instr[2:0];
  assign simm6     = {{10{instr[5]}}, instr[5:0]};
  assign simm9     = {{7{instr[8]}}, instr[8:0]};
  assign rd_val    = (rd == 3'd0) ? 16'h0000 : rf_q[rd];
  assign rs_val    = (rs == 3'd0) ? 16'h0000 : rf_q[rs];
  assign rt_val    = (rt == 3'd0) ? 16'h0000 : rf_q[rt];
  assign sum_imm   = rs_val + simm6;
  assign br_target = pc_q + 16'd1 + simm6;
  assign ld_data   = dmem[sum_imm[7:0]];

  always_comb begin
    alu_y = 16'h0000;
    case (fn)
      3'd0: alu_y = rs_val + rt_val;
      3'd1: alu_y = rs_val - rt_val;
      3'd2: alu_y = rs_val & rt_val;
      3'd3: alu_y = rs_val | rt_val;
      3'd4: alu_y = rs_val ^ rt_val;
      3'd5: alu_y = rs_val << rt_val[3:0];
      3'd6: alu_y = rs_val >> rt_val[3:0];
      default: alu_y = ($signed(rs_val) < $signed(rt_val)) ? 16'd1 : 16'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rf_we    = 1'b0;
    rf_wdata = 16'h0000;
    dm_we    = 1'b0;
    if (state_q == ST_RUN) begin
      pc_d = pc_q + 16'd1;
      case (op)
        4'h0: begin rf_we = 1'b1; rf_wdata = alu_y;   end
        4'h1: begin rf_we = 1'b1; rf_wdata = sum_imm; end
        4'h2: begin rf_we = 1'b1; rf_wdata = ld_data; end
        4'h3: dm_we = 1'b1;
        4'h4: if (rd_val == rs_val) pc_d = br_target;
        4'h5: if (rd_val != rs_val) pc_d = br_target;
        4'h6: pc_d = {4'b0000, instr[11:0]};
        4'h7: begin rf_we = 1'b1; rf_wdata = simm9; end
        4'h8: begin pc_d = pc_q; state_d = ST_HALT; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pc_q    <= 16'h0000;
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (rf_we && (rd != 3'd0)) rf_q[rd] <= rf_wdata;
    end
  end

  // Data RAM keeps its contents across reset; a store is suppressed while reset is held
  always_ff @(posedge clk) begin
    if (dm_we && reset) dmem[sum_imm[7:0]] <= rd_val;
  end

  assign dbg.pc           = pc_q;
  assign dbg.halted       = (state_q == ST_HALT);
  assign dbg.dbg_reg_data = (dbg.dbg_reg_sel == 3'd0) ? 16'h0000 : rf_q[dbg.dbg_reg_sel];
endmodule

// File: tb/tb_s16_cpu.sv
// tb/tb_s16_cpu.sv - self-checking bench for s16_cpu
// An instruction-set model runs beside the core and every retired edge is compared.
module tb_s16_cpu;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  s16_cpu_if bus ();
  s16_cpu #(.IMEM_DEPTH(256), .DMEM_DEPTH(256), .IMEM_FILE("")) dut (
    .clk(clk), .reset(reset), .dbg(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int loop_cnt = 0;
  logic [15:0] prog  [256];
  logic [15:0] m_r   [8];
  logic [15:0] m_mem [256];
  logic [15:0] m_pc;
  logic        m_halt;

  function automatic logic [15:0] e_alu(int rd, int rs, int rt, int fn);
    return {4'h0, 3'(rd), 3'(rs), 3'(rt), 3'(fn)};
  endfunction
  function automatic logic [15:0] e_i(int op, int rd, int rs, int imm);
    return {4'(op), 3'(rd), 3'(rs), 6'(imm)};
  endfunction
  function automatic logic [15:0] e_li(int rd, int imm);
    return {4'h7, 3'(rd), 9'(imm)};
  endfunction
  function automatic logic [15:0] e_jmp(int a);
    return {4'h6, 12'(a)};
  endfunction

  function automatic logic [15:0] m_reg(logic [2:0] i);
    return (i == 3'd0) ? 16'h0000 : m_r[i];
  endfunction
  function automatic int sx16(int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  task automatic m_step();
    logic [15:0] ins;
    int a, b, d, imm, addr, nxt, res;
    bit wr;
    if (m_halt) return;
    ins  = prog[m_pc[7:0]];
    a    = int'(m_reg(ins[8:6]));
    b    = int'(m_reg(ins[5:3]));
    d    = int'(m_reg(ins[11:9]));
    imm  = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
    addr = (a + imm + 65536) % 256;
    nxt  = int'(m_pc) + 1;
    res  = 0;
    wr   = 1'b0;
    case (ins[15:12])
      4'h0: begin
        wr = 1'b1;
        case (ins[2:0])
          3'd0: res = a + b;
          3'd1: res = a - b;
          3'd2: res = a & b;
          3'd3: res = a | b;
          3'd4: res = a ^ b;
          3'd5: res = a << (b % 16);
          3'd6: res = a >> (b % 16);
          default: res = (sx16(a) < sx16(b)) ? 1 : 0;
        endcase
      end
      4'h1: begin wr = 1'b1; res = a + imm; end
      4'h2: begin wr = 1'b1; res = int'(m_mem[addr]); end
      4'h3: m_mem[addr] = 16'(d);
      4'h4: if (d == a) nxt = int'(m_pc) + 1 + imm;
      4'h5: if (d != a) nxt = int'(m_pc) + 1 + imm;
      4'h6: nxt = int'(ins[11:0]);
      4'h7: begin wr = 1'b1; res = ins[8] ? int'(ins[8:0]) - 512 : int'(ins[8:0]); end
      4'h8: begin m_halt = 1'b1; nxt = int'(m_pc); end
      default: ;
    endcase
    if (wr && ins[11:9] != 3'd0) m_r[ins[11:9]] = 16'(res);
    m_pc = 16'(nxt);
  endtask

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic get_reg(input int i, output logic [15:0] v);
    bus.dbg_reg_sel = 3'(i);
    #1;
    v = bus.dbg_reg_data;
  endtask

  task automatic check_reg(input string tag, input int i, input logic [15:0] exp);
    logic [15:0] v;
    get_reg(i, v);
    cmp(tag, v, exp);
  endtask

  task automatic check_all(input string tag);
    logic [15:0] v;
    cmp({tag, "_pc"}, bus.pc, m_pc);
    cmp({tag, "_halted"}, {15'd0, bus.halted}, {15'd0, m_halt});
    for (int s = 0; s < 8; s++) begin
      get_reg(s, v);
      cmp($sformatf("%s_r%0d", tag, s), v, m_reg(3'(s)));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];
    m_pc   = 16'h0000;
    m_halt = 1'b0;
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    check_all("rst_async");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (bus.pc == 16'd14 && !bus.halted) loop_cnt++;
    #1;
    m_step();
    check_all(tag);
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int n = 0;
    while (!m_halt && n < budget) begin
      step(tag);
      n++;
    end
    cmp({tag, "_halt_reached"}, {15'd0, bus.halted}, 16'd1);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'h9000;
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
    bus.dbg_reg_sel = 3'd0;
    #2;

    // fill dmem[i] = i so every later load has a defined value
    clear_prog();
    prog[0] = e_li(2, 255);
    prog[1] = e_i(3, 1, 1, 0);
    prog[2] = e_i(1, 1, 1, 1);
    prog[3] = e_i(5, 1, 2, -3);
    prog[4] = e_i(3, 1, 1, 0);
    prog[5] = 16'h8000;
    do_reset();
    run_to_halt("init", 1000);

    clear_prog();
    prog[0]  = e_li(1, 5);
    prog[1]  = e_li(2, -3);
    prog[2]  = e_alu(3, 1, 2, 0);
    prog[3]  = e_alu(4, 2, 1, 1);
    prog[4]  = e_alu(5, 2, 1, 7);
    prog[5]  = e_li(1, 64);
    prog[6]  = e_li(2, 2);
    prog[7]  = e_alu(6, 1, 2, 5);
    prog[8]  = e_alu(6, 6, 2, 6);
    prog[9]  = e_alu(7, 1, 1, 4);
    prog[10] = e_i(3, 3, 0, 4);
    prog[11] = e_i(2, 6, 0, 4);
    prog[12] = e_i(1, 0, 0, 7);
    prog[13] = e_li(1, 3);
    prog[14] = e_i(1, 1, 1, -1);
    prog[15] = e_i(5, 1, 0, -2);
    prog[16] = 16'h8000;
    do_reset();
    step("a0");
    cmp("first_pc", bus.pc, 16'h0001);
    repeat (4) step("a");
    check_reg("add_r3", 3, 16'h0002);
    check_reg("sub_r4", 4, 16'hFFF8);
    check_reg("slt_r5", 5, 16'h0001);
    repeat (3) step("a");
    check_reg("sll_r6", 6, 16'h0100);
    step("a");
    check_reg("srl_r6", 6, 16'h0040);
    step("a");
    check_reg("xor_r7", 7, 16'h0000);
    repeat (2) step("a");
    check_reg("lw_r6", 6, 16'h0002);
    step("a");
    check_reg("r0_zero", 0, 16'h0000);
    loop_cnt = 0;
    run_to_halt("loop", 40);
    cmp("loop_count", 16'(loop_cnt), 16'd3);
    check_reg("loop_r1", 1, 16'h0000);
    repeat (5) step("frozen");
    cmp("halt_pc", bus.pc, 16'd16);
    cmp("halt_flag", {15'd0, bus.halted}, 16'd1);

    clear_prog();
    prog[0]  = e_jmp(16);
    prog[16] = e_i(2, 1, 0, 4);
    prog[17] = e_li(2, 9);
    prog[18] = e_jmp(16);
    do_reset();
    step("b");
    cmp("jmp_pc", bus.pc, 16'h0010);
    repeat (3) step("b");
    #3;
    do_reset();
    cmp("mid_rst_pc", bus.pc, 16'h0000);
    repeat (2) step("b2");
    check_reg("dmem4_kept", 1, 16'h0002);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) begin
        w = 16'($urandom);
        if (w[15:12] == 4'h8 && $urandom_range(3) != 0) w[15:12] = 4'h0;
        prog[i] = w;
      end
      do_reset();
      repeat (80) step($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
